latch_wr_arbiter: RTL

LATCH_WR_ARBITER -- requirements
Module: latch_wr_arbiter

---
 rtl/latch_wr_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/latch_wr_arbiter.sv
`default_nettype none
// ============================================================================
// latch_wr_arbiter : two-requester round-robin write arbiter sequencing a
//                    shared transparent latch bank (setup / open / hold).
// Optional feature : LATCH_WR_ARBITER_CLEAR_EN adds clr_req / lat_rst.
// Revision         : 1.0
// ============================================================================
module latch_wr_arbiter #(
   parameter int WIDTH       = 8,
   parameter int OPEN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
`ifdef LATCH_WR_ARBITER_CLEAR_EN
   input  logic             clr_req,
   output logic             lat_rst,
`endif
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done,
   output logic [WIDTH-1:0] lat_d,
   output logic             lat_en
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_OPEN  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef LATCH_WR_ARBITER_CLEAR_EN
   localparam logic [2:0] S_CLEAR = 3'd4;
`endif

   logic [2:0]       state_q,  state_d;
   logic [3:0]       cnt_q,    cnt_d;
   logic             last_q,   last_d;   // requester served last; 1 after reset so req0 wins a tie
   logic             gnt0_q,   gnt0_d;
   logic             gnt1_q,   gnt1_d;
   logic             done_q,   done_d;
   logic             lat_en_q, lat_en_d;
   logic [WIDTH-1:0] lat_d_q,  lat_d_d;
`ifdef LATCH_WR_ARBITER_CLEAR_EN
   logic             lat_rst_q, lat_rst_d;
`endif
   logic             win1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      done_d   = done_q;
      lat_en_d = lat_en_q;
      lat_d_d  = lat_d_q;
`ifdef LATCH_WR_ARBITER_CLEAR_EN
      lat_rst_d = lat_rst_q;
`endif
      win1 = (req0 & req1) ? ~last_q : req1;

      case (state_q)
         S_IDLE: begin
`ifdef LATCH_WR_ARBITER_CLEAR_EN
            if (clr_req) begin
               state_d   = S_CLEAR;
               lat_rst_d = 1'b1;
               lat_d_d   = '0;
            end else
`endif
            if (req0 | req1) begin
               state_d = S_SETUP;
               gnt0_d  = ~win1;
               gnt1_d  = win1;
               last_d  = win1;
               lat_d_d = win1 ? data1 : data0;
            end
         end
         S_SETUP: begin
            state_d  = S_OPEN;
            lat_en_d = 1'b1;
            cnt_d    = 4'(OPEN_CYCLES - 1);
         end
         S_OPEN: begin
            if (cnt_q == 4'd0) begin
               state_d  = S_HOLD;
               lat_en_d = 1'b0;
               done_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            state_d = S_IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            done_d  = 1'b0;
         end
`ifdef LATCH_WR_ARBITER_CLEAR_EN
         S_CLEAR: begin
            state_d   = S_IDLE;
            lat_rst_d = 1'b0;
         end
`endif
         default: begin
            state_d  = S_IDLE;
            gnt0_d   = 1'b0;
            gnt1_d   = 1'b0;
            done_d   = 1'b0;
            lat_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         last_q   <= 1'b1;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done_q   <= 1'b0;
         lat_en_q <= 1'b0;
         lat_d_q  <= '0;
`ifdef LATCH_WR_ARBITER_CLEAR_EN
         lat_rst_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done_q   <= done_d;
         lat_en_q <= lat_en_d;
         lat_d_q  <= lat_d_d;
`ifdef LATCH_WR_ARBITER_CLEAR_EN
         lat_rst_q <= lat_rst_d;
`endif
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign done   = done_q;
   assign lat_en = lat_en_q;
   assign lat_d  = lat_d_q;
`ifdef LATCH_WR_ARBITER_CLEAR_EN
   assign lat_rst = lat_rst_q;
`endif

endmodule
`default_nettype wire
